// File: rtl/window_pattern_gen.sv
// Video test-pattern source: raster timing, a programmable sub-window with four
// selectable patterns, measurement of the emitted window size, and a delayed sync copy.
module window_pattern_gen #(
    parameter int DSIZE    = 24,
    parameter int CW       = 12,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int H_ACT    = 1920,
    parameter int H_TOTAL  = 2200,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter int V_ACT    = 1080,
    parameter int V_TOTAL  = 1125,
    parameter int SYNC_LAT = 3
) (
    input  logic             pclk,
    input  logic             prst,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [CW-1:0]    top,
    input  logic [CW-1:0]    left,
    input  logic [CW-1:0]    width,
    input  logic [CW-1:0]    height,
    output logic             vsync,
    output logic             hsync,
    output logic             de,
    output logic [DSIZE-1:0] data,
    output logic             frame_de,
    output logic             sync_vs,
    output logic             sync_hs,
    output logic             sync_de,
    output logic [15:0]      hactive,
    output logic [15:0]      vactive,
    output logic             frame_done
);
    localparam int CH = DSIZE / 3;
    // Wide enough that left+width and top+height never wrap.
    localparam int AW = (CW + 1 > 16) ? CW + 1 : 16;

    localparam logic [AW-1:0] L_HS    = AW'(H_SYNC);
    localparam logic [AW-1:0] L_HOFF  = AW'(H_SYNC + H_BP);
    localparam logic [AW-1:0] L_HEND  = AW'(H_SYNC + H_BP + H_ACT);
    localparam logic [AW-1:0] L_HLAST = AW'(H_TOTAL - 1);
    localparam logic [AW-1:0] L_VS    = AW'(V_SYNC);
    localparam logic [AW-1:0] L_VOFF  = AW'(V_SYNC + V_BP);
    localparam logic [AW-1:0] L_VEND  = AW'(V_SYNC + V_BP + V_ACT);
    localparam logic [AW-1:0] L_VLAST = AW'(V_TOTAL - 1);

    logic [AW-1:0]    r_hcnt, r_vcnt;
    logic [1:0]       r_mode;
    logic [CW-1:0]    r_top, r_left, r_width, r_height;
    logic [CW-1:0]    r_bar_pos;
    logic [2:0]       r_bar_idx;
    logic [15:0]      r_run, r_lines;
    logic             r_vs_q;

    logic             w_origin, w_hact, w_vact, w_win;
    logic [AW-1:0]    w_x, w_y, w_wx, w_wy;
    logic [CW-1:0]    w_bar_len;
    logic [CH-1:0]    w_ch;
    logic             w_chk;
    logic [DSIZE-1:0] w_pix;
    logic             w_de_fall, w_vs_rise;
    logic [15:0]      w_lines_next;

    assign w_origin = (r_hcnt == '0) && (r_vcnt == '0);

    always_ff @(posedge pclk) begin
        if (prst || !enable) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (r_hcnt == L_HLAST) begin
            r_hcnt <= '0;
            r_vcnt <= (r_vcnt == L_VLAST) ? '0 : r_vcnt + AW'(1);
        end else begin
            r_hcnt <= r_hcnt + AW'(1);
        end
    end

    // Counters sit at the origin while disabled, so the first enabled cycle also latches.
    always_ff @(posedge pclk) begin
        if (prst) begin
            r_mode   <= '0;
            r_top    <= '0;
            r_left   <= '0;
            r_width  <= '0;
            r_height <= '0;
        end else if (w_origin) begin
            r_mode   <= mode;
            r_top    <= top;
            r_left   <= left;
            r_width  <= width;
            r_height <= height;
        end
    end

    assign w_hact = (r_hcnt >= L_HOFF) && (r_hcnt < L_HEND);
    assign w_vact = (r_vcnt >= L_VOFF) && (r_vcnt < L_VEND);
    assign w_x    = r_hcnt - L_HOFF;
    assign w_y    = r_vcnt - L_VOFF;
    assign w_win  = w_hact && w_vact
                 && (w_x >= AW'(r_left)) && (w_x < AW'(r_left) + AW'(r_width))
                 && (w_y >= AW'(r_top))  && (w_y < AW'(r_top) + AW'(r_height));
    assign w_wx   = w_x - AW'(r_left);
    assign w_wy   = w_y - AW'(r_top);
    assign w_ch   = CH'(w_wx);
    assign w_chk  = ((w_wx & AW'(16)) != '0) ^ ((w_wy & AW'(16)) != '0);
    assign w_bar_len = ((r_width >> 3) == '0) ? CW'(1) : (r_width >> 3);

    // Bar index tracked incrementally per line instead of dividing wx by bar_len.
    always_ff @(posedge pclk) begin
        if (prst || !enable || !w_win) begin
            r_bar_pos <= '0;
            r_bar_idx <= '0;
        end else if (r_bar_pos == w_bar_len - CW'(1)) begin
            r_bar_pos <= '0;
            if (r_bar_idx != 3'd7) r_bar_idx <= r_bar_idx + 3'd1;
        end else begin
            r_bar_pos <= r_bar_pos + CW'(1);
        end
    end

    always_comb begin
        w_pix = '0;
        case (r_mode)
            2'd0: w_pix = '1;
            2'd1: w_pix = {{CH{r_bar_idx[2]}}, {CH{r_bar_idx[1]}}, {CH{r_bar_idx[0]}}};
            2'd2: w_pix = {3{w_ch}};
            default: w_pix = w_chk ? '1 : '0;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (prst || !enable) begin
            vsync      <= 1'b0;
            hsync      <= 1'b0;
            frame_de   <= 1'b0;
            de         <= 1'b0;
            data       <= '0;
            frame_done <= 1'b0;
        end else begin
            vsync      <= r_vcnt < L_VS;
            hsync      <= r_hcnt < L_HS;
            frame_de   <= w_hact && w_vact;
            de         <= w_win;
            data       <= w_win ? w_pix : '0;
            frame_done <= (r_hcnt == L_HLAST) && (r_vcnt == L_VLAST);
        end
    end

    assign w_de_fall    = !de && (r_run != '0);
    assign w_vs_rise    = vsync && !r_vs_q;
    assign w_lines_next = r_lines + 16'(w_de_fall);

    always_ff @(posedge pclk) begin
        if (prst) begin
            r_run   <= '0;
            r_lines <= '0;
            r_vs_q  <= 1'b0;
            hactive <= '0;
            vactive <= '0;
        end else if (!enable) begin
            r_run   <= '0;
            r_lines <= '0;
            r_vs_q  <= 1'b0;
        end else begin
            r_vs_q <= vsync;
            if (de) begin
                r_run <= r_run + 16'd1;
            end else if (r_run != '0) begin
                hactive <= r_run;
                r_run   <= '0;
            end
            // A line ending on the vsync edge is still counted in the closing frame.
            if (w_vs_rise) begin
                vactive <= w_lines_next;
                r_lines <= '0;
            end else begin
                r_lines <= w_lines_next;
            end
        end
    end

    generate
        if (SYNC_LAT == 0) begin : g_sync_comb
            assign sync_vs = vsync;
            assign sync_hs = hsync;
            assign sync_de = frame_de;
        end else begin : g_sync_dly
            logic [2:0] r_sync_dly [SYNC_LAT];
            always_ff @(posedge pclk) begin
                if (prst || !enable) begin
                    for (int i = 0; i < SYNC_LAT; i++) r_sync_dly[i] <= '0;
                end else begin
                    r_sync_dly[0] <= {vsync, hsync, frame_de};
                    for (int i = 1; i < SYNC_LAT; i++) r_sync_dly[i] <= r_sync_dly[i-1];
                end
            end
            assign {sync_vs, sync_hs, sync_de} = r_sync_dly[SYNC_LAT-1];
        end
    endgenerate
endmodule

// File: tb/tb_window_pattern_gen.sv
// Bench for window_pattern_gen: table vectors, hand sequences for corner cases,
// and randomized stimulus against a frame-position reference model.
module tb_window_pattern_gen;
    localparam int DSIZE = 24, CW = 12, CH = DSIZE / 3;
    localparam int HS = 2, HBP = 3, HACT = 36, HT = 44;
    localparam int VS = 1, VBP = 2, VACT = 20, VT = 24;
    localparam int LAT = 3;
    localparam int FRAME = HT * VT;

    logic             pclk = 1'b0;
    logic             prst, enable;
    logic [1:0]       mode;
    logic [CW-1:0]    top, left, width, height;
    logic             vsync, hsync, de, frame_de, sync_vs, sync_hs, sync_de, frame_done;
    logic [DSIZE-1:0] data;
    logic [15:0]      hactive, vactive;

    always #5 pclk = ~pclk;

    window_pattern_gen #(
        .DSIZE(DSIZE), .CW(CW),
        .H_SYNC(HS), .H_BP(HBP), .H_ACT(HACT), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BP(VBP), .V_ACT(VACT), .V_TOTAL(VT),
        .SYNC_LAT(LAT)
    ) dut (
        .pclk(pclk), .prst(prst), .enable(enable), .mode(mode),
        .top(top), .left(left), .width(width), .height(height),
        .vsync(vsync), .hsync(hsync), .de(de), .data(data), .frame_de(frame_de),
        .sync_vs(sync_vs), .sync_hs(sync_hs), .sync_de(sync_de),
        .hactive(hactive), .vactive(vactive), .frame_done(frame_done)
    );

    int n_tests = 0, n_fail = 0, cyc = 0;

    // Reference model state: position within the frame plus expected outputs.
    int p = 0;
    int m_mode = 0, m_top = 0, m_left = 0, m_w = 0, m_h = 0;
    bit e_vs, e_hs, e_de, e_fde, e_fd;
    logic [DSIZE-1:0] e_data;
    logic [2:0] hist [LAT];
    logic [2:0] e_sync;
    int e_hact = 0, e_vact = 0, run = 0, lines_done = 0, pend_h = 0, pend_v = 0;
    bit ph = 0, pv = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [DSIZE-1:0] pix(int md, int wx, int wy, int w);
        int bl, b;
        logic [CH-1:0] c;
        logic [DSIZE-1:0] r;
        r = '0;
        case (md)
            0: r = '1;
            1: begin
                bl = (w / 8 < 1) ? 1 : w / 8;
                b  = wx / bl;
                if (b > 7) b = 7;
                r = {{CH{b[2]}}, {CH{b[1]}}, {CH{b[0]}}};
            end
            2: begin
                c = CH'(wx % (1 << CH));
                r = {c, c, c};
            end
            default: r = (((wx / 16) % 2) != ((wy / 16) % 2)) ? '1 : '0;
        endcase
        return r;
    endfunction

    task automatic clear_outs();
        e_vs = 0; e_hs = 0; e_de = 0; e_fde = 0; e_fd = 0; e_data = '0;
        for (int i = 0; i < LAT; i++) hist[i] = '0;
        e_sync = '0;
        run = 0; lines_done = 0; ph = 0; pv = 0;
    endtask

    task automatic model_step();
        int hc, vc, x, y;
        bit nvs, nhs, nfde, nde, nfd;
        logic [DSIZE-1:0] nd;
        if (prst) begin
            clear_outs();
            p = 0; m_mode = 0; m_top = 0; m_left = 0; m_w = 0; m_h = 0;
            e_hact = 0; e_vact = 0;
        end else if (!enable) begin
            clear_outs();
            if (p == 0) begin
                m_mode = mode; m_top = top; m_left = left; m_w = width; m_h = height;
            end
            p = 0;
        end else begin
            if (ph) e_hact = pend_h;
            if (pv) e_vact = pend_v;
            ph = 0; pv = 0;
            hc = p % HT; vc = p / HT;
            x = hc - (HS + HBP); y = vc - (VS + VBP);
            nvs  = vc < VS;
            nhs  = hc < HS;
            nfde = (x >= 0) && (x < HACT) && (y >= 0) && (y < VACT);
            nde  = nfde && (x >= m_left) && (x < m_left + m_w) && (y >= m_top) && (y < m_top + m_h);
            nd   = nde ? pix(m_mode, x - m_left, y - m_top, m_w) : '0;
            nfd  = (p == FRAME - 1);
            if (p == 0) begin
                m_mode = mode; m_top = top; m_left = left; m_w = width; m_h = height;
            end
            if (e_de && !nde) begin
                pend_h = run; ph = 1; lines_done++;
            end
            run = nde ? run + 1 : 0;
            if (!e_vs && nvs) begin
                pend_v = lines_done; pv = 1; lines_done = 0;
            end
            for (int i = LAT - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = {e_vs, e_hs, e_fde};
            e_sync = hist[LAT-1];
            e_vs = nvs; e_hs = nhs; e_fde = nfde; e_de = nde; e_data = nd; e_fd = nfd;
            p = (p + 1) % FRAME;
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        model_step();
        cyc++;
        #1;
        check("vsync", vsync, e_vs);
        check("hsync", hsync, e_hs);
        check("de", de, e_de);
        check("data", data, e_data);
        check("frame_de", frame_de, e_fde);
        check("frame_done", frame_done, e_fd);
        check("sync_vs", sync_vs, e_sync[2]);
        check("sync_hs", sync_hs, e_sync[1]);
        check("sync_de", sync_de, e_sync[0]);
        check("hactive", hactive, e_hact);
        check("vactive", vactive, e_vact);
    endtask

    typedef struct {
        int mode, top, left, width, height;
        int exp_hact, exp_vact, exp_de;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [6];
        int dec, k, k1, k2, fd1, fd2, rv, rs;
        bit pvs, pss;
        int h_hold, v_hold;

        tbl[0] = '{0, 1, 2, 4, 3, 4, 3, 12};
        tbl[1] = '{0, 1, 34, 8, 3, 2, 3, 6};
        tbl[2] = '{0, 1, 2, 0, 3, 2, 0, 0};
        tbl[3] = '{3, 0, 0, 32, 20, 32, 20, 640};
        tbl[4] = '{2, 5, 3, 40, 30, 33, 15, 495};
        tbl[5] = '{1, 0, 4, 24, 2, 24, 2, 48};

        prst = 1; enable = 0; mode = 0; top = 0; left = 0; width = 0; height = 0;
        repeat (3) tick();
        check("rst_hactive", hactive, 0);
        check("rst_vactive", vactive, 0);
        check("rst_de", de, 0);
        check("rst_sync_vs", sync_vs, 0);
        prst = 0;

        foreach (tbl[v]) begin
            enable = 0;
            mode = tbl[v].mode; top = tbl[v].top; left = tbl[v].left;
            width = tbl[v].width; height = tbl[v].height;
            repeat (3) tick();
            enable = 1;
            dec = 0;
            for (int i = 0; i < 2 * FRAME; i++) begin
                tick();
                if (de) dec++;
            end
            check("tbl_hactive", hactive, tbl[v].exp_hact);
            check("tbl_vactive", vactive, tbl[v].exp_vact);
            check("tbl_de_count", dec, 2 * tbl[v].exp_de);
        end

        // Mid-frame coefficient change only moves the next frame.
        enable = 0; mode = 0; top = 1; left = 2; width = 4; height = 3;
        repeat (3) tick();
        enable = 1;
        k = 0; k1 = -1; k2 = -1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            k++;
            if (k == FRAME / 2) left = 5;
            if (de && k1 < 0) k1 = k;
            else if (de && k > FRAME && k2 < 0) k2 = k;
        end
        check("first_de", k1, 184);
        check("latch_shift", k2 - k1, FRAME + 3);

        // frame_done period and sync delay.
        fd1 = -1; fd2 = -1; rv = -1; rs = -1; pvs = vsync; pss = sync_vs;
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            if (frame_done) begin
                if (fd1 < 0) fd1 = i;
                else if (fd2 < 0) fd2 = i;
            end
            if (vsync && !pvs && rv < 0) rv = i;
            if (sync_vs && !pss && rv >= 0 && rs < 0) rs = i;
            pvs = vsync; pss = sync_vs;
        end
        check("frame_done_period", fd2 - fd1, FRAME);
        check("sync_vs_lag", rs - rv, LAT);

        // Enable drop mid-line: outputs clear, measurements hold, restart at origin.
        repeat (50) tick();
        h_hold = hactive; v_hold = vactive;
        check("hold_hactive_pre", h_hold, 4);
        check("hold_vactive_pre", v_hold, 3);
        enable = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("drop_hactive", hactive, 4);
            check("drop_vactive", vactive, 3);
            check("drop_hsync", hsync, 0);
            check("drop_sync_de", sync_de, 0);
        end
        enable = 1;
        tick();
        check("restart_hsync", hsync, 1);
        check("restart_vsync", vsync, 1);

        // One-cycle reset mid-line.
        repeat (200) tick();
        prst = 1;
        tick();
        check("prst_hactive", hactive, 0);
        check("prst_vactive", vactive, 0);
        check("prst_frame_de", frame_de, 0);
        check("prst_data", data, 0);
        prst = 0;
        tick();
        check("prst_restart_hsync", hsync, 1);
        repeat (10) tick();

        // Randomized coefficients, modes, enable drops and resets.
        for (int s = 0; s < 25; s++) begin
            mode   = 2'($urandom_range(0, 3));
            top    = CW'($urandom_range(0, 22));
            left   = CW'($urandom_range(0, 40));
            width  = CW'($urandom_range(0, 40));
            height = CW'($urandom_range(0, 24));
            for (int i = 0; i < int'($urandom_range(200, 1500)); i++) begin
                int r;
                r = $urandom_range(0, 999);
                if (r < 3) enable = 0;
                else if (!enable && r < 300) enable = 1;
                prst = (r == 999);
                tick();
            end
            prst = 0; enable = 1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
